square_ctl: RTL and testbench
=============================

# square_ctl

Motion controller that sequences the on-screen square drawn by `draw_square`. It produces the square's top-left position (`xpos_square`, `ypos_square`) once per video frame, and runs a three-state life cycle: hold at spawn, fall under gravity with left/right steering, then land and respawn. It sits in the game-logic clock domain (`clk`, the pixel clock). It takes `vblnk` from the timing chain and user requests from the input decoder.

## Interface
Parameters:
- `X_START`, 300, spawn x (top-left)
- `Y_START`, 30, spawn y
- `X_MIN`, 0, smallest allowed x
- `X_MAX`, 792, largest allowed x (screen width minus square width)
- `Y_FLOOR`, 592, largest allowed y (landing line)
- `STEP_X`, 8, pixels per horizontal move
- `STEP_Y`, 8, pixels per gravity step
- `FALL_DIV`, 4, frames per gravity step (≥1)
- `LAND_FRAMES`, 60, frames spent in LANDED before respawn (≥1)

Ports:
- `clk`  in  1  pixel clock
- `rst`  in  1  synchronous, active-high reset
- `vblnk`  in  1  vertical blank from the timing chain
- `start`  in  1  single-cycle request to begin falling
- `left`  in  1  single-cycle move-left request
- `right`  in  1  single-cycle move-right request
- `drop`  in  1  level; fast drop (only when the macro is defined)
- `xpos_square`  out  12  square x, registered
- `ypos_square`  out  12  square y, registered
- `state`  out  2  current state, encoded as `square_state_t`
- `landed`  out  1  one-cycle pulse on entry to LANDED

## Operation
- **Frame tick.** `tick` is asserted for one cycle, the cycle after a 0→1 edge on registered `vblnk`. All position updates happen only on `tick`.
- **Move requests.**
  - A `left` or `right` pulse sets a sticky request flag. The flag is consumed (cleared) on the next `tick`.
  - If both flags are set at that `tick`, they cancel: no x move, and both flags are cleared.
  - Requests arriving outside FALL are discarded (flags held at 0).
- **IDLE:**
  - x = `X_START`, y = `Y_START`, frame counter = 0.
  - `start` → FALL. `start` takes effect in any cycle, not just on `tick`.
- **FALL, on each `tick`:**
  - x ± `STEP_X`, saturating to [`X_MIN`, `X_MAX`]. Computed at 13 bits, so a move below 0 clamps rather than wraps.
  - The frame counter increments. When it reaches `FALL_DIV`−1, it resets to 0 and y += `STEP_Y`.
  - If y + `STEP_Y` > `Y_FLOOR`: y = `Y_FLOOR`, go to LANDED, pulse `landed`.
  - The x and y updates on the same `tick` are both applied.
- **LANDED:**
  - Position is frozen.
  - Count `LAND_FRAMES` ticks, then go to IDLE (respawn to the start position on the same `tick`).
  - `start` is ignored.
- **Reset** at any point (including mid-fall): state IDLE, x = `X_START`, y = `Y_START`, counters 0, flags 0, `landed` 0, edge register 0.

## Timing
- `vblnk` rising at cycle n → `tick` at n+1 → new position visible on outputs at n+2.
- `start` at cycle n → `state` = FALL at n+1. The first gravity step happens `FALL_DIV` ticks later.
- `landed` is high exactly one cycle, coincident with the first cycle `state` = LANDED.
- Outputs change only at most once per frame. They are therefore stable across the active video region.

## Configuration
- **`SQUARE_CTL_FASTDROP_EN` defined:** while in FALL with `drop` = 1, every `tick` applies y += 4·`STEP_Y` and resets the frame counter. The floor clamp is unchanged.
- **Undefined:** the `drop` port exists but is ignored. Gravity is governed only by `FALL_DIV`.

## Structure
- **Package `square_pkg`:** `square_state_t` enum (IDLE=0, FALL=1, LANDED=2), default screen/square constants, and the position width (12).
- **Sub-module `frame_tick`:** registered `vblnk` rising-edge detector with a one-cycle `tick` output. It is reused by other frame-rate logic.

## Test plan
- **Reset and start:** reset, `start`, then 4 vblnk edges → y 30→38; x stays 300; `state`=1.
- **Steering saturation:** `X_START`=4, `left` pulse, 1 tick → x=0 (no wrap). Separately, `right` at x=788 → x=792.
- **Simultaneous moves:** `left` and `right` pulsed before the same tick → x unchanged; both flags cleared; the next tick has no move.
- **Landing:** fall from y=590 (`FALL_DIV`=1) → y=592; `landed` pulses once; `state`=2. After 60 ticks → `state`=0, position (300,30).
- **Reset mid-fall:** assert `rst` at y=200 → next cycle (300,30), IDLE, `landed`=0; a pending `left` request is lost.
- **Fast drop (macro on):** `drop`=1 at y=100 → y=132 after one tick. With the macro off, the same stimulus leaves y=100 until the `FALL_DIV`-th tick.

Source files
------------

// File: rtl/square_pkg.sv
`default_nettype none
// ============================================================================
// Module   : square_pkg
// Brief    : Shared state type, screen constants and saturating-move helper
//            for the falling-square motion controller.
// Revision : 1.0  initial release
// ============================================================================
package square_pkg;

    localparam int c_POS_W         = 12;
    localparam int c_SCREEN_W      = 800;
    localparam int c_SCREEN_H      = 600;
    localparam int c_SQUARE_SIZE   = 8;
    localparam int c_DEF_X_START   = 300;
    localparam int c_DEF_Y_START   = 30;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FALL   = 2'd1,
        LANDED = 2'd2
    } square_state_t;

    // One extra bit so a step below zero clamps instead of wrapping.
    function automatic logic [c_POS_W-1:0] sat_move(
        input logic [c_POS_W-1:0] pos,
        input logic               dec,
        input logic               inc,
        input logic [c_POS_W-1:0] step,
        input logic [c_POS_W-1:0] lo,
        input logic [c_POS_W-1:0] hi
    );
        logic signed [c_POS_W:0] v;
        v = $signed({1'b0, pos});
        if (dec && !inc)
            v = v - $signed({1'b0, step});
        else if (inc && !dec)
            v = v + $signed({1'b0, step});
        if (v < $signed({1'b0, lo}))
            v = $signed({1'b0, lo});
        else if (v > $signed({1'b0, hi}))
            v = $signed({1'b0, hi});
        return v[c_POS_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/square_ctl_if.sv
`default_nettype none
// ============================================================================
// Module   : square_ctl_if
// Brief    : Request/position bundle between the input decoder, timing chain
//            and the square motion controller.
// Revision : 1.0  initial release
// ============================================================================
interface square_ctl_if;
    import square_pkg::*;

    logic                vblnk;
    logic                start;
    logic                left;
    logic                right;
    logic                drop;
    logic [c_POS_W-1:0]  xpos_square;
    logic [c_POS_W-1:0]  ypos_square;
    square_state_t       state;
    logic                landed;

    modport master (
        output vblnk, start, left, right, drop,
        input  xpos_square, ypos_square, state, landed
    );

    modport slave (
        input  vblnk, start, left, right, drop,
        output xpos_square, ypos_square, state, landed
    );

endinterface
`default_nettype wire

// File: rtl/frame_tick.sv
`default_nettype none
// ============================================================================
// Module   : frame_tick
// Brief    : Registered vblnk rising-edge detector; one-cycle tick per frame.
// Revision : 1.0  initial release
// ============================================================================
module frame_tick (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_vblnk,
    output logic      o_tick
);

    logic r_vblnk;
    logic r_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vblnk <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_vblnk <= i_vblnk;
            r_tick  <= i_vblnk & ~r_vblnk;
        end
    end

    assign o_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/square_ctl.sv
`default_nettype none
// ============================================================================
// Module   : square_ctl
// Brief    : Per-frame position sequencer for the on-screen square:
//            IDLE (spawn) -> FALL (gravity + steering) -> LANDED -> respawn.
//            Define SQUARE_CTL_FASTDROP_EN to enable the drop (fast fall) input.
// Revision : 1.0  initial release
// ============================================================================
module square_ctl
    import square_pkg::*;
#(
    parameter int X_START     = c_DEF_X_START,
    parameter int Y_START     = c_DEF_Y_START,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = c_SCREEN_W - c_SQUARE_SIZE,
    parameter int Y_FLOOR     = c_SCREEN_H - c_SQUARE_SIZE,
    parameter int STEP_X      = 8,
    parameter int STEP_Y      = 8,
    parameter int FALL_DIV    = 4,
    parameter int LAND_FRAMES = 60
) (
    input  wire logic   clk,
    input  wire logic   rst,
    square_ctl_if.slave sq
);

    localparam int c_CNT_MAX = (FALL_DIV > LAND_FRAMES) ? FALL_DIV : LAND_FRAMES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_POS_W-1:0] c_X_START = c_POS_W'(X_START);
    localparam logic [c_POS_W-1:0] c_Y_START = c_POS_W'(Y_START);
    localparam logic [c_POS_W-1:0] c_X_MIN   = c_POS_W'(X_MIN);
    localparam logic [c_POS_W-1:0] c_X_MAX   = c_POS_W'(X_MAX);
    localparam logic [c_POS_W-1:0] c_Y_FLOOR = c_POS_W'(Y_FLOOR);
    localparam logic [c_POS_W-1:0] c_STEP_X  = c_POS_W'(STEP_X);
    localparam logic [c_POS_W:0]   c_STEP_DY = (c_POS_W+1)'(STEP_Y);
    localparam logic [c_POS_W:0]   c_DROP_DY = (c_POS_W+1)'(4 * STEP_Y);
    localparam logic [c_POS_W:0]   c_FLOOR_W = (c_POS_W+1)'(Y_FLOOR);
    localparam logic [c_CNT_W-1:0] c_FALL_LAST = c_CNT_W'(FALL_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_LAND_LAST = c_CNT_W'(LAND_FRAMES - 1);

    square_state_t      r_state, w_state_next;
    logic [c_POS_W-1:0] r_x, w_x_next;
    logic [c_POS_W-1:0] r_y, w_y_next;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_next;
    logic               r_left_req, w_left_next;
    logic               r_right_req, w_right_next;
    logic               r_landed, w_landed_next;
    logic               w_tick;
    logic               w_fast;
    logic               w_step_en;
    logic [c_POS_W:0]   w_dy;
    logic [c_POS_W:0]   w_y_sum;

    frame_tick u_frame_tick (
        .clk     (clk),
        .rst     (rst),
        .i_vblnk (sq.vblnk),
        .o_tick  (w_tick)
    );

`ifdef SQUARE_CTL_FASTDROP_EN
    assign w_fast = sq.drop;
`else
    logic w_unused_drop;
    assign w_fast        = 1'b0;
    assign w_unused_drop = sq.drop;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_x         <= c_X_START;
            r_y         <= c_Y_START;
            r_cnt       <= '0;
            r_left_req  <= 1'b0;
            r_right_req <= 1'b0;
            r_landed    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_x         <= w_x_next;
            r_y         <= w_y_next;
            r_cnt       <= w_cnt_next;
            r_left_req  <= w_left_next;
            r_right_req <= w_right_next;
            r_landed    <= w_landed_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_x_next      = r_x;
        w_y_next      = r_y;
        w_cnt_next    = r_cnt;
        w_left_next   = 1'b0;
        w_right_next  = 1'b0;
        w_landed_next = 1'b0;
        w_step_en     = 1'b0;
        w_dy          = '0;
        w_y_sum       = '0;

        case (r_state)
            IDLE: begin
                w_x_next   = c_X_START;
                w_y_next   = c_Y_START;
                w_cnt_next = '0;
                if (sq.start)
                    w_state_next = FALL;
            end

            FALL: begin
                if (w_tick) begin
                    w_x_next = sat_move(r_x, r_left_req, r_right_req,
                                        c_STEP_X, c_X_MIN, c_X_MAX);
                    if (w_fast) begin
                        w_step_en  = 1'b1;
                        w_dy       = c_DROP_DY;
                        w_cnt_next = '0;
                    end else if (r_cnt == c_FALL_LAST) begin
                        w_step_en  = 1'b1;
                        w_dy       = c_STEP_DY;
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = r_cnt + c_CNT_W'(1);
                    end

                    w_y_sum = {1'b0, r_y} + w_dy;
                    if (w_step_en) begin
                        if (w_y_sum > c_FLOOR_W) begin
                            w_y_next      = c_Y_FLOOR;
                            w_state_next  = LANDED;
                            w_landed_next = 1'b1;
                            w_cnt_next    = '0;
                        end else begin
                            w_y_next = w_y_sum[c_POS_W-1:0];
                        end
                    end
                end

                // Flags seen on this tick are consumed; a pulse arriving in the
                // tick cycle itself is kept for the following tick.
                if (w_state_next == FALL) begin
                    w_left_next  = sq.left  | (r_left_req  & ~w_tick);
                    w_right_next = sq.right | (r_right_req & ~w_tick);
                end
            end

            LANDED: begin
                if (w_tick) begin
                    if (r_cnt == c_LAND_LAST) begin
                        w_state_next = IDLE;
                        w_x_next     = c_X_START;
                        w_y_next     = c_Y_START;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + c_CNT_W'(1);
                    end
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign sq.xpos_square = r_x;
    assign sq.ypos_square = r_y;
    assign sq.state       = r_state;
    assign sq.landed      = r_landed;

endmodule
`default_nettype wire

// File: tb/tb_square_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_square_ctl
// Brief    : Directed, table-driven bench for square_ctl (default instance plus
//            a fast-gravity instance spawned near the left edge and the floor).
// Revision : 1.0  initial release
// ============================================================================
module tb_square_ctl;
    import square_pkg::*;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    square_ctl_if if_a ();
    square_ctl_if if_b ();

    square_ctl dut_a (
        .clk (clk),
        .rst (rst_a),
        .sq  (if_a.slave)
    );

    square_ctl #(
        .X_START  (4),
        .Y_START  (574),
        .FALL_DIV (1)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .sq  (if_b.slave)
    );

    typedef struct {
        logic rst;
        logic start;
        logic left;
        logic right;
        logic frame;
        int   x;
        int   y;
        int   st;
        int   ld;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_a(input string name, input int x, input int y, input int st, input int ld);
        check({name, ".x"},      32'(if_a.xpos_square), x);
        check({name, ".y"},      32'(if_a.ypos_square), y);
        check({name, ".state"},  32'(if_a.state),       st);
        check({name, ".landed"}, 32'(if_a.landed),      ld);
    endtask

    task automatic check_b(input string name, input int x, input int y, input int st, input int ld);
        check({name, ".x"},      32'(if_b.xpos_square), x);
        check({name, ".y"},      32'(if_b.ypos_square), y);
        check({name, ".state"},  32'(if_b.state),       st);
        check({name, ".landed"}, 32'(if_b.landed),      ld);
    endtask

    task automatic pulse_a(input logic s, input logic l, input logic r);
        @(negedge clk);
        if_a.start = s; if_a.left = l; if_a.right = r;
        @(negedge clk);
        if_a.start = 1'b0; if_a.left = 1'b0; if_a.right = 1'b0;
    endtask

    task automatic pulse_b(input logic s, input logic l, input logic r);
        @(negedge clk);
        if_b.start = s; if_b.left = l; if_b.right = r;
        @(negedge clk);
        if_b.start = 1'b0; if_b.left = 1'b0; if_b.right = 1'b0;
    endtask

    // vblnk high for one cycle; returns two cycles later, when the update is visible.
    task automatic frame();
        @(negedge clk);
        if_a.vblnk = 1'b1; if_b.vblnk = 1'b1;
        @(negedge clk);
        if_a.vblnk = 1'b0; if_b.vblnk = 1'b0;
        @(negedge clk);
    endtask

    task automatic reset_a();
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_y;

        rst_a = 1'b1; rst_b = 1'b1;
        if_a.vblnk = 1'b0; if_a.start = 1'b0; if_a.left = 1'b0; if_a.right = 1'b0; if_a.drop = 1'b0;
        if_b.vblnk = 1'b0; if_b.start = 1'b0; if_b.left = 1'b0; if_b.right = 1'b0; if_b.drop = 1'b0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        //                 rst   start left  right frame  x    y   st ld
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 300, 30, 0, 0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 300, 30, 1, 0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 300, 30, 1, 0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 300, 30, 1, 0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 300, 30, 1, 0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 300, 38, 1, 0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 292, 38, 1, 0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 300, 38, 1, 0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 300, 38, 1, 0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 300, 46, 1, 0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 300, 30, 0, 0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 300, 30, 0, 0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 300, 30, 1, 0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 300, 30, 1, 0};

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].rst)
                reset_a();
            if (vecs[i].start || vecs[i].left || vecs[i].right)
                pulse_a(vecs[i].start, vecs[i].left, vecs[i].right);
            if (vecs[i].frame)
                frame();
            check_a($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].st, vecs[i].ld);
        end

        // Third tick, then the fourth tick observed cycle by cycle: no change at n+1.
        frame();
        @(negedge clk);
        if_a.vblnk = 1'b1;
        @(negedge clk);
        if_a.vblnk = 1'b0;
        check("latency.n1_y", 32'(if_a.ypos_square), 30);
        @(negedge clk);
        check("latency.n2_y", 32'(if_a.ypos_square), 38);

        // Right steering saturates at X_MAX.
        for (int k = 0; k < 61; k++) begin
            pulse_a(1'b0, 1'b0, 1'b1);
            frame();
        end
        check("sat_right.x788", 32'(if_a.xpos_square), 788);
        pulse_a(1'b0, 1'b0, 1'b1);
        frame();
        check("sat_right.x792", 32'(if_a.xpos_square), 792);
        pulse_a(1'b0, 1'b0, 1'b1);
        frame();
        check("sat_right.hold", 32'(if_a.xpos_square), 792);
        check("sat_right.state", 32'(if_a.state), 1);

        // Reset mid-fall drops a pending left request.
        pulse_a(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        check_a("midrst", 300, 30, 0, 0);
        rst_a = 1'b0;
        pulse_a(1'b1, 1'b0, 1'b0);
        frame();
        check_a("midrst.lost_left", 300, 30, 1, 0);

        // Drop input: fast fall when enabled, ignored otherwise.
        reset_a();
        pulse_a(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        if_a.drop = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            frame();
`ifdef SQUARE_CTL_FASTDROP_EN
            exp_y = 30 + 32 * k;
`else
            exp_y = (k == 4) ? 38 : 30;
`endif
            check($sformatf("drop.tick%0d.y", k), 32'(if_a.ypos_square), exp_y);
        end
        if_a.drop = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;

        // Instance B: left clamp at 0, landing, landed pulse, respawn.
        pulse_b(1'b1, 1'b0, 1'b0);
        check("b.start.state", 32'(if_b.state), 1);
        pulse_b(1'b0, 1'b1, 1'b0);
        frame();
        check_b("b.tick1", 0, 582, 1, 0);
        frame();
        check_b("b.tick2", 0, 590, 1, 0);
        frame();
        check_b("b.land", 0, 592, 2, 1);
        @(negedge clk);
        check("b.land.pulse_end", 32'(if_b.landed), 0);
        pulse_b(1'b1, 1'b0, 1'b0);
        check("b.land.start_ignored", 32'(if_b.state), 2);
        for (int k = 0; k < 59; k++)
            frame();
        check_b("b.land59", 0, 592, 2, 0);
        frame();
        check_b("b.respawn", 4, 574, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
